// File: rtl/flasher_pkg.sv
// Shared types and constants for bound_flasher and the flick scheduler in
// front of it.
//   FS_IDLE / FS_RUN      scheduler state
//   LED_W                 width of the flasher LED bus
//   LED_KB5 / LED_KB10    the LED images at which a kickback flick is legal
//   led_view_t            per-cycle decoded view of the LED bus
//   is_kb_pat()           true when an LED image is one of the kickback points
package flasher_pkg;

  localparam int LED_W = 16;
  localparam logic [LED_W-1:0] LED_KB5  = 16'h003F;
  localparam logic [LED_W-1:0] LED_KB10 = 16'h07FF;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fs_state_e;

  typedef struct packed {
    logic zero;    // bus is all off
    logic same;    // bus equals last cycle's image
    logic kb;      // kickback pattern just entered
  } led_view_t;

  function automatic logic is_kb_pat(input logic [LED_W-1:0] led);
    return (led == LED_KB5) || (led == LED_KB10);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Searches req from ptr upward with wrap-around and
// grants the first set bit.
//   req      request vector
//   ptr      index where the search starts
//   en       grant enable; gnt is all zero when low
//   gnt      one-hot grant
//   next_ptr index just above the winner (wrapped); equals ptr when no grant
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  localparam int SW = PW + 1;
  localparam logic [SW-1:0] NW   = SW'(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i never exceeds 2N-2, so one conditional subtract wraps it
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= NW) sum = sum - NW;
      idx = sum[PW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = (idx == LAST) ? '0 : idx + PW'(1);
      end
    end
  end

endmodule

// File: rtl/flick_scheduler.sv
// Shares the single flick input of bound_flasher between N_REQ requesters.
// Requests latch into pending flags and are granted round-robin, either to
// start an idle flasher or as a kickback flick on entry to the led[5] /
// led[10] boundary images. A frozen LED bus during a run raises a sticky
// fault and drops the scheduler back to IDLE.
//   clk, rst_n   clock, synchronous active-low reset
//   req_i        per-requester request pulses (set pending flags)
//   led_i        flasher LED bus
//   flick_o      single-cycle flick pulse to the flasher
//   grant_o      one-hot winner, coincident with flick_o
//   busy_o       scheduler is in RUN
//   kick_cnt_o   kicks granted in the current run
//   fault_o      sticky stall flag
module flick_scheduler
  import flasher_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_KICKS = 2,
  parameter int IDLE_CYC  = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_i,
  input  logic [LED_W-1:0]               led_i,
  output logic                           flick_o,
  output logic [N_REQ-1:0]               grant_o,
  output logic                           busy_o,
  output logic [$clog2(MAX_KICKS+1)-1:0] kick_cnt_o,
  output logic                           fault_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int KW = $clog2(MAX_KICKS + 1);
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  fs_state_e        state, state_nxt;
  logic [N_REQ-1:0] pend;
  logic [PW-1:0]    rr;
  logic [PW-1:0]    next_ptr;
  logic [N_REQ-1:0] gnt;
  logic [LED_W-1:0] led_q;
  logic [KW-1:0]    kick_cnt;
  logic [IW-1:0]    idle_cnt;
  logic [TW-1:0]    stall_cnt;
  led_view_t        led_v;

  logic arb_en, kick, set_fault, idle_hit, stall_hit, stay_run;

  always_comb begin
    led_v      = '0;
    led_v.zero = (led_i == '0);
    led_v.same = (led_i == led_q);
    // only the entry cycle of a pattern counts, so a held image kicks once
    led_v.kb   = is_kb_pat(led_i) && !led_v.same;
  end

  // hit flags fire on the cycle that completes the run of zeros / repeats
  assign idle_hit  = led_v.zero && (idle_cnt == IW'(IDLE_CYC - 1));
  assign stall_hit = led_v.same && (stall_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    kick      = 1'b0;
    set_fault = 1'b0;
    case (state)
      FS_IDLE: begin
        // a lit bus in IDLE means someone else started the flasher
        if (|pend && led_v.zero) begin
          arb_en    = 1'b1;
          state_nxt = FS_RUN;
        end
      end
      FS_RUN: begin
        if (led_v.kb && |pend && (kick_cnt < KW'(MAX_KICKS))) begin
          arb_en = 1'b1;
          kick   = 1'b1;
        end
        // an all-off bus is a finished run, not a stall
        if (idle_hit) begin
          state_nxt = FS_IDLE;
        end else if (stall_hit) begin
          set_fault = 1'b1;
          state_nxt = FS_IDLE;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
    // keep the Mealy flick quiet while reset is being applied
    if (!rst_n) arb_en = 1'b0;
  end

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req      (pend),
    .ptr      (rr),
    .en       (arb_en),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  assign stay_run = (state == FS_RUN) && (state_nxt == FS_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FS_IDLE;
      pend      <= '0;
      rr        <= '0;
      led_q     <= '0;
      kick_cnt  <= '0;
      idle_cnt  <= '0;
      stall_cnt <= '0;
      fault_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      led_q <= led_i;
      // set wins over the grant clear on the same bit
      pend  <= (pend & ~gnt) | req_i;
      if (arb_en) rr <= next_ptr;
      if (set_fault) fault_o <= 1'b1;
      if (stay_run) begin
        idle_cnt  <= led_v.zero ? idle_cnt + IW'(1) : '0;
        stall_cnt <= led_v.same ? stall_cnt + TW'(1) : '0;
        if (kick) kick_cnt <= kick_cnt + KW'(1);
      end else begin
        idle_cnt  <= '0;
        stall_cnt <= '0;
        kick_cnt  <= '0;
      end
    end
  end

  assign flick_o    = |gnt;
  assign grant_o    = gnt;
  assign busy_o     = (state == FS_RUN);
  assign kick_cnt_o = kick_cnt;

endmodule

// File: tb/tb_flick_scheduler.sv
module tb_flick_scheduler;
  import flasher_pkg::*;

  localparam int N  = 4;
  localparam int MK = 2;
  localparam int IC = 4;
  localparam int TO = 64;
  localparam int KW = $clog2(MK + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [15:0]   led_i = '0;
  logic          flick_o;
  logic [N-1:0]  grant_o;
  logic          busy_o;
  logic [KW-1:0] kick_cnt_o;
  logic          fault_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flick_scheduler #(.N_REQ(N), .MAX_KICKS(MK), .IDLE_CYC(IC), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .led_i      (led_i),
    .flick_o    (flick_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .kick_cnt_o (kick_cnt_o),
    .fault_o    (fault_o)
  );

  // reference model: a run flag, a set of pending requesters, a rotating
  // priority start point and a few "how many cycles in a row" tallies
  bit           m_run, m_fault;
  logic [N-1:0] m_pend;
  int           m_rr, m_kicks, m_zeros, m_same;
  logic [15:0]  m_prev;
  int           exp_w;

  task automatic model_reset();
    m_run = 0; m_fault = 0; m_pend = '0; m_rr = 0; m_kicks = 0;
    m_zeros = 0; m_same = 0; m_prev = '0; exp_w = -1;
  endtask

  task automatic end_run();
    m_run = 0; m_kicks = 0; m_zeros = 0; m_same = 0;
  endtask

  function automatic int winner();
    for (int i = 0; i < N; i++) begin
      int k = (m_rr + i) % N;
      if (((m_pend >> k) & N'(1)) != '0) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // apply inputs mid-cycle and compare everything against the model
  task automatic drive(input logic [N-1:0] req, input logic [15:0] led, input logic rst = 1'b0);
    bit opp;
    int w;
    @(negedge clk);
    req_i = req; led_i = led; rst_n = ~rst;
    #1;
    w = winner();
    if (rst) opp = 0;
    else if (!m_run) opp = (led == 16'h0);
    else opp = (led == 16'h003F || led == 16'h07FF) && (led != m_prev) && (m_kicks < MK);
    if (!opp) w = -1;
    exp_w = w;
    chk("flick", 32'(flick_o), (w >= 0) ? 32'd1 : 32'd0);
    chk("grant", 32'(grant_o), (w >= 0) ? 32'(1 << w) : 32'd0);
    chk("busy", 32'(busy_o), 32'(m_run));
    chk("kick_cnt", 32'(kick_cnt_o), 32'(m_kicks));
    chk("fault", 32'(fault_o), 32'(m_fault));
  endtask

  task automatic tick();
    bit was_run;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_run = m_run;
    if (was_run) begin
      m_zeros = (led_i == 16'h0) ? m_zeros + 1 : 0;
      m_same  = (led_i == m_prev) ? m_same + 1 : 0;
    end
    if (exp_w >= 0) begin
      m_pend = m_pend & ~N'(1 << exp_w);
      m_rr = (exp_w + 1) % N;
      if (was_run) m_kicks++;
      else m_run = 1;
    end
    if (was_run) begin
      if (m_zeros == IC) end_run();
      else if (m_same == TO) begin
        m_fault = 1;
        end_run();
      end
    end
    m_pend = m_pend | req_i;
    m_prev = led_i;
  endtask

  task automatic cyc(input logic [N-1:0] req, input logic [15:0] led, input logic rst = 1'b0);
    drive(req, led, rst);
    tick();
  endtask

  function automatic logic [15:0] ramp(input int k);
    return 16'((32'd1 << k) - 32'd1);
  endfunction

  initial begin
    int n;
    int hold;
    logic [15:0] led_r;
    logic [N-1:0] rq;
    logic rs;

    model_reset();
    cyc('0, 16'h0, 1'b1);
    cyc('0, 16'h0, 1'b1);

    // reset state
    drive('0, 16'h0);
    chk("rst_flick", 32'(flick_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_kick", 32'(kick_cnt_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    tick();

    // single start: request, then flick next cycle, busy the cycle after
    cyc(4'b0001, 16'h0);
    drive('0, 16'h0);
    chk("start_flick", 32'(flick_o), 32'd1);
    chk("start_grant", 32'(grant_o), 32'b0001);
    tick();
    drive('0, 16'h0001);
    chk("start_busy", 32'(busy_o), 32'd1);
    tick();
    for (int k = 2; k <= 16; k++) cyc('0, ramp(k));
    for (int i = 0; i < IC; i++) cyc('0, 16'h0);
    drive('0, 16'h0);
    chk("run_end_idle", 32'(busy_o), 32'd0);
    tick();

    // round-robin: start goes to 0, first kick to 1
    cyc('0, 16'h0, 1'b1);
    cyc(4'b0011, 16'h0);
    drive('0, 16'h0);
    chk("rr_start_grant", 32'(grant_o), 32'b0001);
    tick();
    for (int k = 1; k <= 5; k++) cyc('0, ramp(k));
    drive('0, 16'h003F);
    chk("rr_kick_flick", 32'(flick_o), 32'd1);
    chk("rr_kick_grant", 32'(grant_o), 32'b0010);
    tick();
    drive('0, 16'h007F);
    chk("rr_kick_cnt", 32'(kick_cnt_o), 32'd1);
    tick();
    for (int i = 0; i < IC; i++) cyc('0, 16'h0);

    // kick cap: four pending, one start + MK kicks, the last waits
    cyc('0, 16'h0, 1'b1);
    cyc(4'b1111, 16'h0);
    drive('0, 16'h0);
    chk("cap_start_grant", 32'(grant_o), 32'b0001);
    tick();
    for (int k = 1; k <= 5; k++) cyc('0, ramp(k));
    drive('0, 16'h003F);
    chk("cap_kick1_grant", 32'(grant_o), 32'b0010);
    tick();
    for (int k = 7; k <= 10; k++) cyc('0, ramp(k));
    drive('0, 16'h07FF);
    chk("cap_kick2_grant", 32'(grant_o), 32'b0100);
    tick();
    cyc('0, 16'h0FFF);
    drive('0, 16'h07FF);
    chk("cap_no_kick", 32'(flick_o), 32'd0);
    chk("cap_kick_cnt", 32'(kick_cnt_o), 32'd2);
    tick();
    cyc('0, 16'h003F);
    for (int i = 0; i < IC; i++) cyc('0, 16'h0);
    drive('0, 16'h0);
    chk("cap_next_start", 32'(grant_o), 32'b1000);
    tick();

    // pattern held three cycles gives exactly one pulse
    cyc(4'b0001, 16'h0001);
    cyc('0, 16'h0003);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      drive('0, 16'h07FF);
      n += int'(flick_o);
      tick();
    end
    chk("hold_one_pulse", 32'(n), 32'd1);

    // stall: frozen bus in RUN trips the fault
    for (int i = 0; i < TO - 4; i++) cyc('0, 16'h00FF);
    drive('0, 16'h00FF);
    chk("stall_not_yet", 32'(fault_o), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) cyc('0, 16'h00FF);
    drive('0, 16'h00FF);
    chk("stall_fault", 32'(fault_o), 32'd1);
    chk("stall_busy", 32'(busy_o), 32'd0);
    tick();

    // fault does not block a later start
    cyc(4'b0100, 16'h0);
    drive('0, 16'h0);
    chk("post_fault_start", 32'(grant_o), 32'b0100);
    tick();

    // mid-run reset with a request pending
    cyc('0, 16'h0001);
    cyc(4'b0010, 16'h0003);
    drive('0, 16'h0007, 1'b1);
    chk("mid_rst_flick", 32'(flick_o), 32'd0);
    tick();
    drive('0, 16'h0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_fault", 32'(fault_o), 32'd0);
    chk("mid_rst_pend_clear", 32'(flick_o), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) cyc('0, 16'h0);
    cyc(4'b0001, 16'h0);
    drive('0, 16'h0);
    chk("post_rst_start", 32'(grant_o), 32'b0001);
    tick();

    // randomized traffic against the model
    hold = 0;
    led_r = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0, 1: led_r = 16'h0;
          2: led_r = LED_KB5;
          3: led_r = LED_KB10;
          4: led_r = 16'($urandom);
          default: ;
        endcase
        hold = ($urandom_range(0, 40) == 0) ? 70 : int'($urandom_range(1, 6));
      end
      hold--;
      rq = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rs = ($urandom_range(0, 199) == 0);
      cyc(rq, led_r, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flick_scheduler.md
# flick_scheduler

Controller in front of `bound_flasher` that shares its single `flick` input between several requesters (button, timer, host). Requests are latched as pending flags and granted round-robin. A grant either starts an idle flasher or injects a kickback flick at exactly the flasher's legal kickback points (led[5] or led[10] boundary). The block watches the flasher's `led` bus to detect the idle, running and kickback conditions, and it flags a stalled flasher.

## Interface
- `N_REQ`, 2: number of requesters (2..8)
- `MAX_KICKS`, 2: maximum kickback flicks granted per flasher run
- `IDLE_CYC`, 4: consecutive cycles of `led_i == 0` that declare a run finished
- `TIMEOUT`, 64: cycles with `led_i` unchanged in RUN before a fault is raised
- `clk`  in  1  single system clock, all logic on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_i`  in  N_REQ  per-requester request; a 1 in any cycle sets that requester's pending flag
- `led_i`  in  16  flasher LED bus, sampled directly
- `flick_o`  out  1  drives `bound_flasher.flick`; single-cycle pulse
- `grant_o`  out  N_REQ  one-hot; high in the same cycle as `flick_o`
- `busy_o`  out  1  high while the state is RUN
- `kick_cnt_o`  out  $clog2(MAX_KICKS+1)  number of kicks granted in the current run
- `fault_o`  out  1  sticky stall flag, cleared only by reset

## Operation
- The pending register `pend[N_REQ-1:0]` sets on `req_i` and clears on grant. Set wins when a set and a clear hit the same bit in the same cycle.
- Round-robin pointer `rr`: the arbiter searches from `rr` upward with wrap-around. After a grant to index k, `rr` becomes (k+1) mod N_REQ.
- Kickback pattern match `kb`: `led_i == 16'h003F` or `led_i == 16'h07FF`, and `led_i != led_q`. `led_q` is the previous cycle's `led_i`. The inequality allows one kick per pattern entry.
- FSM states:
  - IDLE
    - If `|pend` and `led_i == 0`: `flick_o` = 1, grant the arbitration winner, go to RUN next cycle.
    - If `led_i != 0`: stay in IDLE and issue no grant, because a foreign start is possible.
  - RUN
    - If `kb`, `|pend` and `kick_cnt < MAX_KICKS`: `flick_o` = 1, grant the winner, increment `kick_cnt`.
    - If `led_i == 0` for IDLE_CYC consecutive cycles: go to IDLE and clear `kick_cnt`.
    - If `led_i` stays unchanged for TIMEOUT cycles: set `fault_o`, go to IDLE, clear `kick_cnt`.
- Pending flags that are not granted persist across runs.
- When `kick_cnt == MAX_KICKS`, further pending flags wait for the next run.
- `flick_o` and `grant_o` are Mealy outputs: combinational from state, `pend`, `rr`, `led_i`, `led_q` and `kick_cnt`. `kb` detection must therefore land in the same cycle as the flick.
- Fault handling: `fault_o` does not block operation. A later IDLE start is still allowed.

## Timing
- Reset values: `flick_o` 0, `grant_o` 0, `busy_o` 0, `kick_cnt_o` 0, `fault_o` 0. Also `pend` 0, `rr` 0, `led_q` 0, state IDLE, counters 0.
- Request to start flick: 1 cycle. A request in cycle t gives `pend` set at t+1 and `flick_o` at t+1 if `led_i == 0`.
- Start flick to `busy_o`: 1 cycle.
- Kick flick: 0 cycles after `led_i` first equals the pattern, provided `pend` was already set.
- At most one `flick_o` pulse per cycle. No two consecutive pulses, because `kb` requires an entry edge.
- Mid-operation reset: all registers return to their reset values. The flasher's own reset is independent. After reset the block waits in IDLE until `led_i == 0`.
- Simultaneous requests: granted in round-robin order, one per grant opportunity.

## Structure
- Package `flasher_pkg`:
  - state enum `FS_IDLE`, `FS_RUN`
  - constants `LED_KB5 = 16'h003F`, `LED_KB10 = 16'h07FF`, `LED_W = 16`
  - shared by `bound_flasher` benches
- Sub-module `rr_arbiter`: parameter `N`; inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and `next_ptr`.
- Top level: pending register, FSM, three counters (idle run, stall, kick), `led_q`.

## Test plan
- Single start:
  - Stimulus: `req_i=2'b01` for one cycle with `led_i=0`.
  - Response: next cycle `flick_o=1`, `grant_o=2'b01`; following cycle `busy_o=1`.
- Round-robin:
  - Stimulus: `req_i=2'b11` in IDLE.
  - Response: start grant goes to 01. At the first `led_i=16'h003F` entry, kick grant goes to 10 and `kick_cnt_o=1`.
- Kick cap:
  - Stimulus: `MAX_KICKS=1`, three requests pending, two pattern entries.
  - Response: only one kick. The remaining request starts the next run after `led_i=0` for 4 cycles.
- Pattern hold:
  - Stimulus: `led_i` held at `16'h07FF` for 3 cycles with `pend` set.
  - Response: exactly one `flick_o` pulse.
- Stall:
  - Stimulus: `led_i` frozen at `16'h00FF` for 64 cycles in RUN.
  - Response: `fault_o=1`, `busy_o=0`.
- Reset:
  - Stimulus: `rst_n=0` for 1 cycle mid-run with `pend=2'b10`.
  - Response: all outputs 0, `pend` cleared, no flick until a new request arrives.
